ikaopll_acc_mixer: RTL and testbench

IKAOPLL_ACC_MIXER -- requirements
Module: ikaopll_acc_mixer

---
 rtl/ikaopll_acc_mixer_pkg.sv | 37 +++
 rtl/ikaopll_acc_sat.sv | 39 +++
 rtl/ikaopll_acc_mixer.sv | 116 +++++++++++
 tb/tb_ikaopll_acc_mixer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ikaopll_acc_mixer_pkg.sv
// Shared widths and saturation helper for the OPLL DAC accumulator/mixer.
// Defaults here size the mixer and its clamp path.
package ikaopll_acc_mixer_pkg;

    localparam int DEF_NUM_STREAMS = 2;
    localparam int DEF_SAMPLE_W    = 10;
    localparam int DEF_VOL_W       = 5;
    localparam int DEF_OUT_W       = 16;
    localparam int DEF_GUARD_W     = 4;
    localparam int DEF_ACC_W       = DEF_OUT_W + DEF_GUARD_W;

    typedef struct packed {
        logic                        clip;
        logic signed [DEF_OUT_W-1:0] val;
    } sat_res_t;

    // Reduce an accumulator to output width; clip flags lost high bits.
    function automatic sat_res_t sat_default(
        input logic signed [DEF_ACC_W-1:0] acc,
        input logic                        wrap
    );
        sat_res_t           r;
        logic [DEF_GUARD_W:0] hi;
        logic               ext_ok;
        hi     = acc[DEF_ACC_W-1:DEF_OUT_W-1];
        ext_ok = (&hi) | ~(|hi);
        r.clip = ~ext_ok;
        r.val  = acc[DEF_OUT_W-1:0];
        if (!ext_ok && !wrap) begin
            r.val = acc[DEF_ACC_W-1]
                  ? {1'b1, {(DEF_OUT_W-1){1'b0}}}
                  : {1'b0, {(DEF_OUT_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/ikaopll_acc_sat.sv
// Combinational clamp or wrap of the frame accumulator to output width.
// clip is raised whenever the discarded high bits are not a sign extension.
module ikaopll_acc_sat
    import ikaopll_acc_mixer_pkg::*;
#(
    parameter int ACC_W    = DEF_ACC_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] sample,
    output logic                    clip
);

    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    logic ovf;

    generate
        if (ACC_W > OUT_W) begin : g_guard
            logic [ACC_W-OUT_W:0] hi;
            assign hi  = acc[ACC_W-1:OUT_W-1];
            assign ovf = ~((&hi) | ~(|hi));
        end else begin : g_noguard
            assign ovf = 1'b0;
        end
    endgenerate

    always_comb begin
        sample = acc[OUT_W-1:0];
        if (SATURATE && ovf) begin
            sample = acc[ACC_W-1] ? MIN_V : MAX_V;
        end
    end

    assign clip = ovf;

endmodule

// File: rtl/ikaopll_acc_mixer.sv
// Per-frame multiply-accumulate mixer of OPLL DAC streams with volume,
// mute, clamp/wrap output conversion and sticky clip/frame-error flags.
module ikaopll_acc_mixer
    import ikaopll_acc_mixer_pkg::*;
#(
    parameter int NUM_STREAMS = DEF_NUM_STREAMS,
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int VOL_W       = DEF_VOL_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int GUARD_W     = DEF_GUARD_W,
    parameter bit SATURATE    = 1'b1,
    parameter int MAX_SAMPLES = 18,
    localparam int SEL_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
    input  logic                          i_EMUCLK,
    input  logic                          i_RST_n,
    input  logic                          i_phi1_NCEN_n,
    input  logic                          i_CYCLE_00,
    input  logic                          i_DAC_EN,
    input  logic [SEL_W-1:0]              i_STREAM_SEL,
    input  logic signed [SAMPLE_W-1:0]    i_SAMPLE,
    input  logic [NUM_STREAMS*VOL_W-1:0]  i_VOL,
    input  logic [NUM_STREAMS-1:0]        i_MUTE,
    input  logic                          i_CLIP_CLR,
    output logic                          o_STRB,
    output logic signed [OUT_W-1:0]       o_SAMPLE,
    output logic                          o_CLIP,
    output logic                          o_FRAME_ERR
);

    localparam int PROD_W  = SAMPLE_W + VOL_W;
    localparam int ACC_W   = OUT_W + GUARD_W;
    localparam int CNT_MAX = MAX_SAMPLES + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic                    tick;
    logic signed [VOL_W-1:0] vol_sel;
    logic                    sel_live;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  add;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    err_set;
    logic signed [OUT_W-1:0] sat_val;
    logic                    sat_clip;

    assign tick = ~i_phi1_NCEN_n;

    // Out-of-range selects match no stream and leave the product at zero.
    always_comb begin
        vol_sel  = '0;
        sel_live = 1'b0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            if (i_STREAM_SEL == SEL_W'(k)) begin
                vol_sel  = i_VOL[k*VOL_W +: VOL_W];
                sel_live = ~i_MUTE[k];
            end
        end
    end

    always_comb begin
        prod = '0;
        if (sel_live) begin
            prod = PROD_W'(i_SAMPLE) * PROD_W'(vol_sel);
        end
        add = i_DAC_EN ? ACC_W'(prod) : '0;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (i_CYCLE_00) begin
            cnt_nxt = i_DAC_EN ? CNT_W'(1) : '0;
        end else if (i_DAC_EN && cnt != CNT_W'(CNT_MAX)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        err_set = (cnt_nxt == CNT_W'(CNT_MAX))
                && (i_CYCLE_00 || cnt != CNT_W'(CNT_MAX));
    end

    ikaopll_acc_sat #(
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W),
        .SATURATE (SATURATE)
    ) u_sat (
        .acc    (acc),
        .sample (sat_val),
        .clip   (sat_clip)
    );

    // Strobe drops on the next EMUCLK regardless of the phi1 enable.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            acc         <= '0;
            cnt         <= '0;
            o_SAMPLE    <= '0;
            o_STRB      <= 1'b0;
            o_CLIP      <= 1'b0;
            o_FRAME_ERR <= 1'b0;
        end else begin
            o_STRB <= tick & i_CYCLE_00;
            if (tick) begin
                acc <= i_CYCLE_00 ? add : acc + add;
                cnt <= cnt_nxt;
                if (i_CYCLE_00) begin
                    o_SAMPLE <= sat_val;
                end
                o_CLIP <= (i_CYCLE_00 & sat_clip)
                        | (o_CLIP & ~i_CLIP_CLR);
                o_FRAME_ERR <= err_set
                             | (o_FRAME_ERR & ~i_CLIP_CLR);
            end
        end
    end

endmodule

// File: tb/tb_ikaopll_acc_mixer.sv
// Scoreboard bench: a saturating and a wrapping 3-stream mixer are driven
// with shared stimulus and checked against a frame-sum reference model.
module tb_ikaopll_acc_mixer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ncen = 1'b1;
    logic c0 = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic [1:0] sel = '0;
    logic signed [9:0] smp = '0;
    logic [9:0] vol_pk_a = '0;
    logic [14:0] vol_pk_b = '0;
    logic [1:0] mute_pk_a = '0;
    logic [2:0] mute_pk_b = '0;

    logic strb_a, clip_a, ferr_a;
    logic strb_b, clip_b, ferr_b;
    logic signed [15:0] samp_a, samp_b;

    typedef struct {
        int smp;
        bit clip;
        bit ferr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int vol[2][4];
    bit mute[2][4];
    longint m_acc[2];
    int m_cnt[2];
    bit m_clip[2];
    bit m_ferr[2];
    int n_pass = 0;
    int n_tot = 0;

    localparam int NS[2] = '{2, 3};
    localparam bit SATM[2] = '{1'b1, 1'b0};
    localparam int MAXS = 18;

    always #5 clk = ~clk;

    ikaopll_acc_mixer #(.SATURATE(1)) u_a (
        .i_EMUCLK      (clk),
        .i_RST_n       (rst_n),
        .i_phi1_NCEN_n (ncen),
        .i_CYCLE_00    (c0),
        .i_DAC_EN      (en),
        .i_STREAM_SEL  (sel[0]),
        .i_SAMPLE      (smp),
        .i_VOL         (vol_pk_a),
        .i_MUTE        (mute_pk_a),
        .i_CLIP_CLR    (clr),
        .o_STRB        (strb_a),
        .o_SAMPLE      (samp_a),
        .o_CLIP        (clip_a),
        .o_FRAME_ERR   (ferr_a)
    );

    ikaopll_acc_mixer #(.NUM_STREAMS(3), .SATURATE(0)) u_b (
        .i_EMUCLK      (clk),
        .i_RST_n       (rst_n),
        .i_phi1_NCEN_n (ncen),
        .i_CYCLE_00    (c0),
        .i_DAC_EN      (en),
        .i_STREAM_SEL  (sel),
        .i_SAMPLE      (smp),
        .i_VOL         (vol_pk_b),
        .i_MUTE        (mute_pk_b),
        .i_CLIP_CLR    (clr),
        .o_STRB        (strb_b),
        .o_SAMPLE      (samp_b),
        .o_CLIP        (clip_b),
        .o_FRAME_ERR   (ferr_b)
    );

    task automatic chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic longint wrapn(longint a, int w);
        longint m;
        m = longint'(1) << w;
        return ((a + m / 2) % m + m) % m - m / 2;
    endfunction

    // Reference: frame sum of sample*volume, converted at frame close.
    task automatic model_tick(int d);
        int s;
        longint p, a;
        bit cs, es;
        exp_t e;
        s = (d == 0) ? int'(sel[0]) : int'(sel);
        p = 0;
        cs = 0;
        es = 0;
        if (en && s < NS[d] && !mute[d][s]) p = longint'(smp) * vol[d][s];
        if (c0) begin
            a = m_acc[d];
            cs = (a > 32767) || (a < -32768);
            if (SATM[d]) e.smp = (a > 32767) ? 32767 : (a < -32768) ? -32768 : int'(a);
            else e.smp = int'(wrapn(a, 16));
            m_acc[d] = p;
            m_cnt[d] = en ? 1 : 0;
        end else begin
            m_acc[d] = wrapn(m_acc[d] + p, 20);
            if (en) m_cnt[d]++;
        end
        es = en && (m_cnt[d] == MAXS + 1);
        m_clip[d] = cs | (m_clip[d] & !clr);
        m_ferr[d] = es | (m_ferr[d] & !clr);
        if (c0) begin
            e.clip = m_clip[d];
            e.ferr = m_ferr[d];
            if (d == 0) q_a.push_back(e);
            else q_b.push_back(e);
        end
    endtask

    task automatic pack_cfg();
        for (int k = 0; k < 2; k++) begin
            vol_pk_a[k*5 +: 5] = 5'(vol[0][k]);
            mute_pk_a[k] = mute[0][k];
        end
        for (int k = 0; k < 3; k++) begin
            vol_pk_b[k*5 +: 5] = 5'(vol[1][k]);
            mute_pk_b[k] = mute[1][k];
        end
    endtask

    task automatic step(bit c, bit e, int s, int x, bit k, bit nc);
        @(negedge clk);
        pack_cfg();
        c0 = c;
        en = e;
        sel = 2'(s);
        smp = 10'(x);
        clr = k;
        ncen = nc;
        if (rst_n && !nc) begin
            model_tick(0);
            model_tick(1);
        end
    endtask

    task automatic do_reset(int n);
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0;
            m_cnt[d] = 0;
            m_clip[d] = 0;
            m_ferr[d] = 0;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            ncen = 1'($urandom_range(0, 1));
            c0 = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 1));
            smp = 10'($urandom_range(0, 1023));
        end
        @(negedge clk);
        chk("rst_strb_a", int'(strb_a), 0);
        chk("rst_samp_a", int'(samp_a), 0);
        chk("rst_clip_a", int'(clip_a), 0);
        chk("rst_ferr_a", int'(ferr_a), 0);
        chk("rst_strb_b", int'(strb_b), 0);
        chk("rst_samp_b", int'(samp_b), 0);
        chk("rst_clip_b", int'(clip_b), 0);
        chk("rst_ferr_b", int'(ferr_b), 0);
        rst_n = 1'b1;
        ncen = 1'b1;
        c0 = 1'b0;
        en = 1'b0;
    endtask

    task automatic mon(int d, int s, bit c, bit f);
        exp_t e;
        int avail;
        avail = (d == 0) ? q_a.size() : q_b.size();
        chk(d == 0 ? "strb_a_expected" : "strb_b_expected", int'(avail > 0), 1);
        if (avail > 0) begin
            e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
            chk(d == 0 ? "sample_a" : "sample_b", s, e.smp);
            chk(d == 0 ? "clip_a" : "clip_b", int'(c), int'(e.clip));
            chk(d == 0 ? "ferr_a" : "ferr_b", int'(f), int'(e.ferr));
        end
    endtask

    always @(negedge clk) begin
        if (strb_a) mon(0, int'(samp_a), clip_a, ferr_a);
        if (strb_b) mon(1, int'(samp_b), clip_b, ferr_b);
    end

    task automatic set_all(int v, bit m);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                vol[d][k] = v;
                mute[d][k] = m;
            end
    endtask

    initial begin
        bit bias;
        set_all(0, 0);
        do_reset(2);
        step(1, 0, 0, 0, 0, 0);

        // Two-stream mix: 9*100*1 + 5*50*(-2) = 400
        set_all(0, 0);
        vol[0][0] = 1; vol[0][1] = -2;
        vol[1][0] = 1; vol[1][1] = -2; vol[1][2] = 3;
        repeat (9) step(0, 1, 0, 100, 0, 0);
        step(0, 1, 0, 300, 0, 1);
        repeat (5) step(0, 1, 1, 50, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // 18*511*15: clamps to 32767, wraps to 6898; set beats clear
        set_all(15, 0);
        repeat (18) step(0, 1, 0, 511, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);

        // Mute stream 0; sel=3 is a stream-1 alias on the 1-bit select
        set_all(1, 0);
        mute[0][0] = 1;
        mute[1][0] = 1;
        for (int i = 0; i < 6; i++) step(0, 1, i % 2, 200, 0, 0);
        repeat (2) step(0, 1, 3, 200, 0, 0);
        step(1, 1, 0, 123, 0, 0);
        mute[0][0] = 0;
        mute[1][0] = 0;
        step(1, 0, 0, 0, 0, 0);

        // 19 samples in one frame
        repeat (19) step(0, 1, 1, -5, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);

        // Reset mid-frame, then clean frames
        repeat (7) step(0, 1, 0, 77, 0, 0);
        do_reset(2);
        repeat (4) step(0, 1, 1, 10, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, -3, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        bias = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset(1 + $urandom_range(0, 2));
            if ($urandom_range(0, 149) == 0) begin
                bias = 1'($urandom_range(0, 1));
                for (int d = 0; d < 2; d++)
                    for (int k = 0; k < 4; k++) begin
                        vol[d][k] = int'($urandom_range(0, 31)) - 16;
                        mute[d][k] = ($urandom_range(0, 4) == 0);
                    end
            end
            step($urandom_range(0, 29) == 0,
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)),
                 bias ? 511 : int'($urandom_range(0, 1023)) - 512,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) == 0);
        end

        repeat (4) step(0, 0, 0, 0, 0, 1);
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
